// File: rtl/nibble_pkg.sv
// Shared constants, FSM state type and sizing helpers for the nibble-serial negation sequencer.
package nibble_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int calc_nnib(input int width);
    return width / NIB_W;
  endfunction

  // A counter for a single nibble still needs one bit so the port/array is never zero-width.
  function automatic int calc_cnt_w(input int width);
    int n;
    n = calc_nnib(width);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_comp_slice.sv
// One 4-bit complement-and-increment slice: {cout, y} = ~a + cin.
module nibble_comp_slice
  import nibble_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic             cin,
  output logic [NIB_W-1:0] y,
  output logic             cout
);

  assign {cout, y} = {1'b0, ~a} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_negate_seq.sv
// Two's complement of a WIDTH-bit operand, one nibble per cycle through a single slice,
// LSB nibble first, with the result returned over a valid/ready handshake.
module nibble_negate_seq
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] comp,
  output logic             carry_out,
  output logic             overflow
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE, out_valid only in HOLD; both come straight from the state flop.
  localparam int NNIB = calc_nnib(WIDTH);
  localparam int CW   = calc_cnt_w(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(NNIB - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [NIB_W-1:0] op_nib;
  logic [NIB_W-1:0] nib;
  logic             cout;

  assign op_nib = op[NIB_W*cnt +: NIB_W];

  nibble_comp_slice u_slice (
    .a    (op_nib),
    .cin  (carry),
    .y    (nib),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= a;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res[NIB_W*cnt +: NIB_W] <= nib;
          carry                   <= cout;
          if (cnt == LAST) begin
            cnt       <= '0;
            carry_out <= cout;
            overflow  <= (op == MIN_VAL);
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign comp      = res;

endmodule

// File: tb/tb_nibble_negate_seq.sv
// Bench for nibble_negate_seq: a 16-bit and a 4-bit instance checked against plain negation arithmetic.
module tb_nibble_negate_seq;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;
  int          cyc;

  logic        in_valid, in_ready, out_valid, out_ready, carry_out, overflow;
  logic [15:0] a, comp;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, carry_out4, overflow4;
  logic [3:0]  a4, comp4;

  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] comp;
    logic        co;
    logic        ov;
    int          stall;
  } vec_t;

  vec_t vecs[8];

  nibble_negate_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .comp(comp),
    .carry_out(carry_out), .overflow(overflow)
  );

  nibble_negate_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4),
    .out_valid(out_valid4), .out_ready(out_ready4), .comp(comp4),
    .carry_out(carry_out4), .overflow(overflow4)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: negation is simply 2^W - x, reduced modulo 2^W.
  function automatic logic [15:0] neg16(input logic [15:0] x);
    return 16'(17'h10000 - {1'b0, x});
  endfunction

  function automatic logic [3:0] neg4(input logic [3:0] x);
    return 4'(5'h10 - {1'b0, x});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one 16-bit operation; stall = cycles out_ready is held low once out_valid rises.
  task automatic op16(input logic [15:0] av, input logic [15:0] ec, input logic eco,
                      input logic eov, input int stall, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " idle"}, 32'(in_ready), 32'd1);
    a         = av;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    check({tag, " busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " comp"}, 32'(comp), 32'(ec));
    check({tag, " carry_out"}, 32'(carry_out), 32'(eco));
    check({tag, " overflow"}, 32'(overflow), 32'(eov));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = 16'h5555;
      @(posedge clk); #1;
      check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold_comp"}, 32'(comp), 32'(ec));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " done_valid"}, 32'(out_valid), 32'd0);
    check({tag, " done_ready"}, 32'(in_ready), 32'd1);
    check({tag, " idle_comp"}, 32'(comp), 32'(ec));
  endtask

  task automatic op4(input logic [3:0] av, input string tag);
    int n;
    a4         = av;
    in_valid4  = 1'b1;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency4"}, 32'(n), 32'd1);
    check({tag, " comp4"}, 32'(comp4), 32'(neg4(av)));
    check({tag, " carry_out4"}, 32'(carry_out4), 32'(av == 4'h0));
    check({tag, " overflow4"}, 32'(overflow4), 32'(av == 4'h8));
    @(posedge clk); #1;
    check({tag, " done4"}, 32'(in_ready4), 32'd1);
  endtask

  initial begin
    int   n;
    int   last_acc;
    logic [15:0] r;

    total = 0;
    bad   = 0;
    in_valid = 0; out_ready = 0; a = '0;
    in_valid4 = 0; out_ready4 = 0; a4 = '0;

    vecs[0] = '{16'h0001, 16'hFFFF, 1'b0, 1'b0, 0};
    vecs[1] = '{16'h00F0, 16'hFF10, 1'b0, 1'b0, 0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 0};
    vecs[4] = '{16'h1234, 16'hEDCC, 1'b0, 1'b0, 5};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0};
    vecs[6] = '{16'h7FFF, 16'h8001, 1'b0, 1'b0, 2};
    vecs[7] = '{16'h0002, 16'hFFFE, 1'b0, 1'b0, 1};

    // Reset state
    rst = 1'b1;
    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst comp", 32'(comp), 32'd0);
    check("rst carry_out", 32'(carry_out), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst in_ready4", 32'(in_ready4), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      op16(vecs[i].a, vecs[i].comp, vecs[i].co, vecs[i].ov, vecs[i].stall, $sformatf("vec%0d", i));

    // Reset in the 2nd RUN cycle abandons the operation at once
    a = 16'h00FF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun out_valid", 32'(out_valid), 32'd0);
    check("midrun in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("midrun no_result", 32'(n), 32'd0);
    op16(16'h0002, 16'hFFFE, 1'b0, 1'b0, 0, "after_rst");

    // Random operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom);
      if (i % 10 == 0) r = 16'h8000 >> $urandom_range(0, 1);
      op16(r, neg16(r), r == 16'h0000, r == 16'h8000, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // WIDTH=4 instance
    op4(4'b0101, "w4_a");
    op4(4'b1000, "w4_b");
    op4(4'b0000, "w4_c");

    // Back-to-back on the 4-bit instance: accepts every 3 cycles, results via scoreboard
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    last_acc = -1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid4 && out_ready4) begin
        if (exp_q.size() == 0) check("b2b unexpected", 32'(comp4), 32'hFFFF_FFFF);
        else check("b2b comp4", 32'(comp4), 32'(exp_q.pop_front()));
      end
      a4 = 4'($urandom);
      if (in_ready4) begin
        exp_q.push_back(neg4(a4));
        if (last_acc >= 0) check("b2b spacing", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      if (out_valid4) check("b2b drain", 32'(comp4), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    check("b2b accepts", 32'(n), 32'd10);
    check("b2b leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
